// File: rtl/tx_pattern_gen_v2_if.sv
// AXI4-Stream video bundle for tx_pattern_gen_v2.
// Master drives beats; slave returns tready.
interface tx_pattern_gen_v2_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/tx_pattern_gen_v2.sv
// Tx video test-pattern generator with one-stage registered output.
// Define TX_PATTERN_SCROLL_EN to scroll patterns by one pixel per frame.
module tx_pattern_gen_v2 #(
  parameter int DATA_W    = 32,
  parameter int CW        = 10,
  parameter int POS_W     = 12,
  parameter int BAR_SHIFT = 7,
  parameter int CHK_SHIFT = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           mode,
  tx_pattern_gen_v2_if.slave   s_axis_video,
  tx_pattern_gen_v2_if.master  m_axis_video,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [1:0] {
    M_PASS = 2'd0,
    M_RAMP = 2'd1,
    M_BARS = 2'd2,
    M_CHK  = 2'd3
  } mode_e;

  localparam logic [CW-1:0] FULL = {CW{1'b1}};

  logic              accept;
  logic              s_rdy;
  logic [POS_W-1:0]  x_q, x_d;
  logic [POS_W-1:0]  y_q, y_d;
  logic [POS_W-1:0]  px, py, pat_x;
  mode_e             mode_q, mode_d, mode_cur;
  logic [15:0]       fcnt_q, fcnt_d;
  logic [DATA_W-1:0] data_q, data_d, pix;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic              user_q, user_d;
  logic [2:0]        bar;
  logic              chk;
  logic [CW-1:0]     r, g, b;

  assign s_rdy  = !vld_q || m_axis_video.tready;
  assign accept = s_axis_video.tvalid && s_rdy;

  assign s_axis_video.tready = s_rdy;
  assign m_axis_video.tvalid = vld_q;
  assign m_axis_video.tdata  = data_q;
  assign m_axis_video.tlast  = last_q;
  assign m_axis_video.tuser  = user_q;
  assign frame_cnt           = fcnt_q;

  // A start-of-frame beat already uses the newly sampled mode
  assign mode_cur = s_axis_video.tuser ? mode_e'(mode) : mode_q;

  always_comb begin
    px = s_axis_video.tuser ? '0 : x_q;
    py = s_axis_video.tuser ? '0 : y_q;
`ifdef TX_PATTERN_SCROLL_EN
    pat_x = px + POS_W'(fcnt_q);
`else
    pat_x = px;
`endif
    bar = 3'(pat_x >> BAR_SHIFT);
    chk = pat_x[CHK_SHIFT] ^ py[CHK_SHIFT];
    r   = '0;
    g   = '0;
    b   = '0;
    pix = '0;
    unique case (mode_cur)
      M_PASS: ;
      M_RAMP: begin
        g = CW'(pat_x);
        b = CW'(py);
        r = FULL - CW'(py);
      end
      // Bar order W,Y,C,G,M,R,B,K maps to bit-inverted index
      M_BARS: begin
        r = {CW{~bar[1]}};
        g = {CW{~bar[2]}};
        b = {CW{~bar[0]}};
      end
      M_CHK: begin
        r = {CW{chk}};
        g = {CW{chk}};
        b = {CW{chk}};
      end
    endcase
    if (mode_cur == M_PASS) begin
      pix = s_axis_video.tdata;
    end else begin
      pix[3*CW-1:0] = {r, b, g};
    end
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    fcnt_d = fcnt_q;
    if (accept) begin
      if (s_axis_video.tlast) begin
        x_d = '0;
        y_d = s_axis_video.tuser ? POS_W'(1) : y_q + POS_W'(1);
      end else if (s_axis_video.tuser) begin
        x_d = POS_W'(1);
        y_d = '0;
      end else begin
        x_d = x_q + POS_W'(1);
      end
      if (s_axis_video.tuser) begin
        mode_d = mode_e'(mode);
        fcnt_d = fcnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    last_d = last_q;
    user_d = user_q;
    if (accept) begin
      vld_d  = 1'b1;
      data_d = pix;
      last_d = s_axis_video.tlast;
      user_d = s_axis_video.tuser;
    end else if (m_axis_video.tready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= M_PASS;
      fcnt_q <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      user_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      fcnt_q <= fcnt_d;
      vld_q  <= vld_d;
      data_q <= data_d;
      last_q <= last_d;
      user_q <= user_d;
    end
  end

endmodule

// File: tb/tb_tx_pattern_gen_v2.sv
// Scoreboard bench for tx_pattern_gen_v2.
// Expected beats are queued on acceptance and checked at the output.
module tb_tx_pattern_gen_v2;

  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] frame_cnt;

  tx_pattern_gen_v2_if #(.DATA_W(DATA_W)) s_if ();
  tx_pattern_gen_v2_if #(.DATA_W(DATA_W)) m_if ();

  tx_pattern_gen_v2 dut (
    .clk          (clk),
    .rstn         (rstn),
    .mode         (mode),
    .s_axis_video (s_if),
    .m_axis_video (m_if),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        u;
    int          acc;
  } beat_t;

  beat_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit lat_chk = 0;
  bit rnd_rdy = 0;

  int          mx = 0;
  int          my = 0;
  logic [1:0]  mmode = 2'd0;
  logic [15:0] mfc = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_pix(input logic [31:0] d,
                                          input logic u,
                                          input logic [1:0] md);
    int px, py, sx, bi;
    logic [1:0] am;
    logic [2:0] rgb;
    logic [9:0] r, g, b;
    px = u ? 0 : mx;
    py = u ? 0 : my;
    am = u ? md : mmode;
    sx = px;
`ifdef TX_PATTERN_SCROLL_EN
    sx = (px + int'(mfc)) % 4096;
`endif
    r = '0; g = '0; b = '0; rgb = '0;
    case (am)
      2'd0: return d;
      2'd1: begin
        g = 10'(sx % 1024);
        b = 10'(py % 1024);
        r = 10'(1023 - (py % 1024));
      end
      2'd2: begin
        bi = (sx >> 7) % 8;
        case (bi)
          0: rgb = 3'b111;
          1: rgb = 3'b110;
          2: rgb = 3'b011;
          3: rgb = 3'b010;
          4: rgb = 3'b101;
          5: rgb = 3'b100;
          6: rgb = 3'b001;
          default: rgb = 3'b000;
        endcase
        r = rgb[2] ? 10'h3FF : 10'h0;
        g = rgb[1] ? 10'h3FF : 10'h0;
        b = rgb[0] ? 10'h3FF : 10'h0;
      end
      default: begin
        if ((((sx >> 5) ^ (py >> 5)) & 1) == 1) begin
          r = 10'h3FF; g = 10'h3FF; b = 10'h3FF;
        end
      end
    endcase
    return {2'b00, r, b, g};
  endfunction

  task automatic upd(input logic l, input logic u, input logic [1:0] md);
    if (l) begin
      mx = 0;
      my = u ? 1 : (my + 1) % 4096;
    end else if (u) begin
      mx = 1;
      my = 0;
    end else begin
      mx = (mx + 1) % 4096;
    end
    if (u) begin
      mmode = md;
      mfc = mfc + 16'd1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic u);
    bit ok;
    beat_t e;
    ok = 0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (s_if.tready) begin
        e.d = exp_pix(d, u, mode);
        e.l = l;
        e.u = u;
        e.acc = cyc + 1;
        sbq.push_back(e);
        upd(l, u, mode);
        ok = 1;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    s_if.tvalid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int w, input int h, input bit gaps);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          s_if.tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
        send($urandom, xx == w - 1, xx == 0 && yy == 0);
      end
    end
  endtask

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 m_if.tready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (rstn && m_if.tvalid) begin
      if (sbq.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        e = sbq[0];
        chk("tdata", m_if.tdata, e.d);
        chk("tlast", m_if.tlast, e.l);
        chk("tuser", m_if.tuser, e.u);
        if (lat_chk) chk("latency", cyc, e.acc);
        if (m_if.tready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b1;
    #12;
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tdata", m_if.tdata, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_tuser", m_if.tuser, 0);
    chk("rst_fcnt", frame_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // ramp 4x3 with latency check, then single-pixel lines
    mode = 2'd1;
    lat_chk = 1;
    frame(4, 3, 0);
    drain();
    lat_chk = 0;
    frame(1, 3, 0);
    drain();

    // colour bars on a 1024-pixel line
    mode = 2'd2;
    frame(1024, 1, 0);
    drain();

    // checkerboard covering x,y = 32
    mode = 2'd3;
    frame(40, 33, 0);
    drain();

    // pass-through with random backpressure and input gaps
    mode = 2'd0;
    rnd_rdy = 1;
    frame(50, 3, 1);
    drain();
    rnd_rdy = 0;
    @(posedge clk);
    #2;
    m_if.tready = 1'b1;
    drain();

    // reset while a beat is stalled on the output
    mode = 2'd1;
    send($urandom, 1'b0, 1'b1);
    send($urandom, 1'b0, 1'b0);
    m_if.tready = 1'b0;
    #3;
    chk("stall_tvalid", m_if.tvalid, 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_tvalid", m_if.tvalid, 0);
    chk("rst_mid_tdata", m_if.tdata, 0);
    chk("rst_mid_fcnt", frame_cnt, 0);
    s_if.tvalid = 1'b0;
    sbq.delete();
    mx = 0;
    my = 0;
    mmode = 2'd0;
    mfc = 16'd0;
    @(negedge clk);
    rstn = 1'b1;
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;

    // mode change mid-frame takes effect on next frame
    mode = 2'd1;
    for (int xx = 0; xx < 4; xx++) send($urandom, xx == 3, xx == 0);
    mode = 2'd2;
    for (int xx = 0; xx < 4; xx++) send($urandom, xx == 3, 1'b0);
    drain();
    chk("fcnt_1", frame_cnt, 1);
    frame(4, 2, 0);
    drain();
    chk("fcnt_2", frame_cnt, 2);

    chk("end_idle", m_if.tvalid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
